// File: rtl/seg7_pkg.sv
// Seven-segment constants, display mode encoding and the scroll message.
package seg7_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_N     = 7'b0101011;

    localparam int unsigned NUM_DIGITS = 10;
    localparam logic [6:0] SEG_DIGIT [NUM_DIGITS] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    typedef enum logic [1:0] {
        MODE_SHOW   = 2'd0,
        MODE_BAD    = 2'd1,
        MODE_SCROLL = 2'd2
    } mode_e;

    // Scroll message "bAnAnA" followed by two blanks; length is a power of two
    // so the position counter wraps for free.
    localparam int unsigned MSG_LEN = 8;
    localparam int unsigned POS_W   = 3;
    localparam logic [6:0] MSG_M [MSG_LEN] = '{
        SEG_B, SEG_A, SEG_N, SEG_A, SEG_N, SEG_A, SEG_BLANK, SEG_BLANK
    };

endpackage

// File: rtl/seg7_digit.sv
// Combinational decimal digit decoder; values above 9 render blank.
module seg7_digit
    import seg7_pkg::*;
#(
    parameter int unsigned OP_W = 5
) (
    input  logic [OP_W-1:0] val_i,
    output logic [6:0]      seg_o
);

    // Table lookup with blanking of out-of-range values
    always_comb begin
        seg_o = SEG_BLANK;
        if (val_i <= OP_W'(9)) begin
            seg_o = SEG_DIGIT[4'(val_i)];
        end
    end

endmodule

// File: rtl/hex_msg_display.sv
// Shows operand digits on HEX0.., a blinking "bAd" banner for invalid operands,
// or a scrolling "bAnAnA" message when the special operand pair is present.
module hex_msg_display
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_OPS    = 2,
    parameter int unsigned OP_W       = 5,
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned SPECIAL_HI = 7,
    parameter int unsigned SPECIAL_LO = 12
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic [NUM_OPS*OP_W-1:0] SW,
    output logic [6:0]              HEX0,
    output logic [6:0]              HEX1,
    output logic [6:0]              HEX2,
    output logic [6:0]              HEX3,
    output logic [6:0]              HEX4,
    output logic [6:0]              HEX5
);

    localparam int unsigned SW_W    = NUM_OPS * OP_W;
    localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NUM_HEX = 6;

    logic [SW_W-1:0]  sw_q;
    mode_e            mode_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             hide_q, hide_d;
    logic [6:0]       hex_q [NUM_HEX];
    logic [6:0]       hex_d [NUM_HEX];

    logic [OP_W-1:0]    op_c  [NUM_OPS];
    logic [6:0]         dig_c [NUM_OPS];
    logic [NUM_OPS-1:0] bad_op_c;
    logic               special_c;
    mode_e              mode_c;
    logic               change_c;
    logic               tick_c;

    // Per-operand field extraction, validity and digit decode
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
        assign op_c[gi]     = sw_q[gi*OP_W +: OP_W];
        assign bad_op_c[gi] = (op_c[gi] > OP_W'(9));

        seg7_digit #(.OP_W(OP_W)) u_digit (
            .val_i (op_c[gi]),
            .seg_o (dig_c[gi])
        );
    end

    // The scroll trigger needs two operands; a single-operand build never scrolls
    if (NUM_OPS >= 2) begin : g_special
        assign special_c = (op_c[1] == OP_W'(SPECIAL_HI)) && (op_c[0] == OP_W'(SPECIAL_LO));
    end else begin : g_no_special
        assign special_c = 1'b0;
    end

    // Mode classification: scroll beats bad, bad beats show
    always_comb begin
        mode_c = MODE_SHOW;
        if (special_c) begin
            mode_c = MODE_SCROLL;
        end else if (|bad_op_c) begin
            mode_c = MODE_BAD;
        end
    end

    assign change_c = (mode_c != mode_q);
    assign tick_c   = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Tick, scroll position and blink phase; a mode change restarts all three
    // and swallows any coincident tick.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        pos_d  = pos_q;
        hide_d = hide_q;
        if (change_c) begin
            cnt_d  = '0;
            pos_d  = '0;
            hide_d = 1'b0;
        end else if (tick_c) begin
            cnt_d = '0;
            if (mode_q == MODE_SCROLL) begin
                pos_d = pos_q + POS_W'(1);
            end
            if (mode_q == MODE_BAD) begin
                hide_d = ~hide_q;
            end
        end
    end

    // Display image for the coming cycle, built from the already-updated phase
    always_comb begin
        for (int i = 0; i < NUM_HEX; i++) begin
            hex_d[i] = SEG_BLANK;
        end
        case (mode_c)
            MODE_SCROLL: begin
                for (int k = 0; k < NUM_HEX; k++) begin
                    hex_d[NUM_HEX-1-k] = MSG_M[POS_W'(pos_d + POS_W'(k))];
                end
            end
            MODE_BAD: begin
                for (int i = 0; i < NUM_OPS; i++) begin
                    hex_d[i] = dig_c[i];
                end
                if (!hide_d) begin
                    hex_d[5] = SEG_B;
                    hex_d[4] = SEG_A;
                    hex_d[3] = SEG_D;
                end
            end
            default: begin
                for (int i = 0; i < NUM_OPS; i++) begin
                    hex_d[i] = dig_c[i];
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            sw_q   <= '0;
            mode_q <= MODE_SHOW;
            cnt_q  <= '0;
            pos_q  <= '0;
            hide_q <= 1'b0;
            hex_q  <= '{default: SEG_BLANK};
        end else begin
            sw_q   <= SW;
            mode_q <= mode_c;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            hide_q <= hide_d;
            hex_q  <= hex_d;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_msg_display.sv
// Bench for hex_msg_display: directed scenarios plus randomized switch traffic
// checked every cycle against an elapsed-time reference model.
module tb_hex_msg_display;

    localparam int unsigned NUM_OPS  = 2;
    localparam int unsigned OP_W     = 5;
    localparam int unsigned TICK_DIV = 4;

    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [6:0] S_B  = 7'b0000011;
    localparam logic [6:0] S_A  = 7'b0001000;
    localparam logic [6:0] S_D  = 7'b0100001;
    localparam logic [6:0] S_N  = 7'b0101011;

    localparam logic [9:0] SW_SHOW  = 10'b00111_00011;
    localparam logic [9:0] SW_BAD   = 10'b10111_00011;
    localparam logic [9:0] SW_SPEC  = 10'b00111_01100;
    localparam logic [9:0] SW_BAD2  = 10'b10111_11011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  sw;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [41:0] hexv;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: edge count, registered switches, mode, entry edge
    int         m_n     = 0;
    logic [9:0] m_swq   = '0;
    int         m_mode  = 0;
    int         m_entry = 0;

    always #5 clk = ~clk;

    assign hexv = {hex5, hex4, hex3, hex2, hex1, hex0};

    hex_msg_display #(
        .NUM_OPS    (NUM_OPS),
        .OP_W       (OP_W),
        .TICK_DIV   (TICK_DIV),
        .SPECIAL_HI (7),
        .SPECIAL_LO (12)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .SW       (sw),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5)
    );

    task automatic check_eq(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %b expected %b", tag, m_n, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return S_BL;
        endcase
    endfunction

    function automatic logic [6:0] msg_of(input int i);
        case (i)
            0: return S_B;
            1: return S_A;
            2: return S_N;
            3: return S_A;
            4: return S_N;
            5: return S_A;
            default: return S_BL;
        endcase
    endfunction

    // 0 = show, 1 = bad, 2 = scroll
    function automatic int classify(input logic [9:0] s);
        int op0, op1;
        op0 = int'(s[4:0]);
        op1 = int'(s[9:5]);
        if (op1 == 7 && op0 == 12) return 2;
        if (op0 > 9 || op1 > 9) return 1;
        return 0;
    endfunction

    // Display image from mode, operands and edges elapsed since the mode began
    function automatic logic [41:0] model_hex(input int mode, input logic [9:0] s, input int elapsed);
        logic [6:0] h [6];
        int ticks;
        ticks = elapsed / TICK_DIV;
        for (int i = 0; i < 6; i++) h[i] = S_BL;
        if (mode == 2) begin
            for (int k = 0; k < 6; k++) h[5-k] = msg_of((ticks + k) % 8);
        end else begin
            h[0] = seg_of(int'(s[4:0]));
            h[1] = seg_of(int'(s[9:5]));
            if (mode == 1 && (ticks % 2) == 0) begin
                h[5] = S_B;
                h[4] = S_A;
                h[3] = S_D;
            end
        end
        return {h[5], h[4], h[3], h[2], h[1], h[0]};
    endfunction

    // Drive one cycle of inputs, advance the model, compare after the edge
    task automatic step(input logic [9:0] s, input logic r);
        logic [41:0] exp;
        int md;
        sw      = s;
        reset_n = r;
        @(posedge clk);
        m_n++;
        if (!r) begin
            exp     = {6{S_BL}};
            m_swq   = '0;
            m_mode  = 0;
            m_entry = m_n;
        end else begin
            md = classify(m_swq);
            if (md != m_mode) begin
                m_mode  = md;
                m_entry = m_n;
            end
            exp   = model_hex(m_mode, m_swq, m_n - m_entry);
            m_swq = s;
        end
        #1;
        check_eq(r ? "hex" : "hex_reset", hexv, exp);
    endtask

    task automatic run(input logic [9:0] s, input int cycles);
        for (int i = 0; i < cycles; i++) step(s, 1'b1);
    endtask

    initial begin
        logic [9:0] s;
        int         hold;
        sw      = '0;
        reset_n = 1'b0;

        step(SW_SHOW, 1'b0);
        step(SW_SHOW, 1'b0);
        check_eq("reset_blank", hexv, {6{S_BL}});

        // Plain digits
        run(SW_SHOW, 2);
        check_eq("show_73", hexv, {S_BL, S_BL, S_BL, S_BL, seg_of(7), seg_of(3)});

        // Invalid op1: banner blinks with a 4-cycle half period
        run(SW_BAD, 2);
        check_eq("bad_entry", hexv, {S_B, S_A, S_D, S_BL, S_BL, seg_of(3)});
        run(SW_BAD, 4);
        check_eq("bad_hidden", hexv, {S_BL, S_BL, S_BL, S_BL, S_BL, seg_of(3)});
        run(SW_BAD, 4);
        check_eq("bad_visible", hexv, {S_B, S_A, S_D, S_BL, S_BL, seg_of(3)});

        // Scroll from position 0, one step per tick, full wrap after 32 cycles
        run(SW_SPEC, 2);
        check_eq("scroll_p0", hexv, {S_B, S_A, S_N, S_A, S_N, S_A});
        run(SW_SPEC, 4);
        check_eq("scroll_p1", hexv, {S_A, S_N, S_A, S_N, S_A, S_BL});
        run(SW_SPEC, 28);
        check_eq("scroll_wrap", hexv, {S_B, S_A, S_N, S_A, S_N, S_A});

        // Leave scroll mid-way and come back: restarts at position 0
        run(SW_SPEC, 9);
        run(SW_SHOW, 2);
        check_eq("scroll_exit", hexv, {S_BL, S_BL, S_BL, S_BL, seg_of(7), seg_of(3)});
        run(SW_SPEC, 2);
        check_eq("scroll_restart", hexv, {S_B, S_A, S_N, S_A, S_N, S_A});

        // Reset mid-scroll, then release with valid digits
        run(SW_SPEC, 6);
        step(SW_SPEC, 1'b0);
        check_eq("reset_mid_scroll", hexv, {6{S_BL}});
        run(SW_SHOW, 2);
        check_eq("post_reset_show", hexv, {S_BL, S_BL, S_BL, S_BL, seg_of(7), seg_of(3)});

        // Both operands invalid
        run(SW_BAD2, 2);
        check_eq("bad_both", hexv, {S_B, S_A, S_D, S_BL, S_BL, S_BL});

        // Randomized traffic with occasional resets
        for (int iter = 0; iter < 300; iter++) begin
            case ($urandom_range(0, 4))
                0: s = SW_SPEC;
                1: s = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
                2: s = {5'd7, 5'($urandom_range(8, 15))};
                3: s = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 9))};
                default: s = 10'($urandom);
            endcase
            hold = $urandom_range(1, 20);
            if ($urandom_range(0, 49) == 0) begin
                for (int i = 0; i < $urandom_range(1, 3); i++) step(s, 1'b0);
            end
            run(s, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_msg_display.md
HEX_MSG_DISPLAY -- requirements
Module: hex_msg_display

Interface
REQ-001 Parameter NUM_OPS, default 2: number of operand fields packed into SW; legal range 1..3.
REQ-002 Parameter OP_W, default 5: width of each operand field, in bits; legal range 4..8.
REQ-003 Parameter TICK_DIV, default 25_000_000: CLOCK_50 cycles per display tick (0.5 s).
REQ-004 Parameter SPECIAL_HI, default 7, and SPECIAL_LO, default 12: operand pair that triggers the scroll message.
REQ-005 CLOCK_50  in  1  sole clock; all state on its rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 SW  in  NUM_OPS*OP_W  operands; op i = SW[i*OP_W +: OP_W]; op 0 is the least significant field.
REQ-008 HEX0..HEX5  out  7 each  seven-segment digits, active-low, segment order {g,f,e,d,c,b,a}; HEX5 is leftmost.

Function
REQ-009 SW shall be registered (sw_q) every cycle; all classification shall use sw_q.
REQ-010 HEX outputs shall be registered; latency from a SW change to the HEX change shall be exactly 2 cycles in SHOW and BAD.
REQ-011 An op shall be valid iff its value <= 9.
REQ-012 Mode precedence each cycle: SCROLL iff NUM_OPS>=2, op1==SPECIAL_HI and op0==SPECIAL_LO; else BAD iff any op is invalid; else SHOW.
REQ-013 SHOW: HEX[i] shall show the decimal digit of op i for i<NUM_OPS; all other HEX shall be blank (1111111).
REQ-014 BAD: HEX5/4/3 shall show b(0000011) A(0001000) d(0100001); HEX[i] for i<NUM_OPS shall show op i if valid, else blank; the remaining HEX shall be blank.
REQ-015 BAD: the "bAd" text shall blink, visible on entry, toggling on every tick; digits shall stay steady.
REQ-016 SCROLL: message M = b,A,n(0101011),A,n,A,blank,blank (length 8); at position p, HEX(5-k) = M[(p+k) mod 8] for k=0..5.
REQ-017 SCROLL: p shall be 0 on entry; p shall increment on every tick and wrap from 7 to 0.
REQ-018 Tick counter: counts 0..TICK_DIV-1; the tick asserts in the cycle the count equals TICK_DIV-1, then the count returns to 0.
REQ-019 On any mode change, the tick counter, p and the blink phase shall clear in the same cycle; a tick coinciding with a mode change shall be discarded.
REQ-020 A SW change that keeps the same mode shall not restart the tick counter or the scroll position.
REQ-021 Digit values 0..9 shall use standard active-low encodings (for example 3=0110000, 7=1111000).

Reset
REQ-022 While reset_n=0 at a clock edge: all HEX = 1111111, sw_q=0, mode=SHOW, tick count=0, p=0, blink phase=visible.
REQ-023 A reset asserted mid-scroll or mid-blink shall take effect on the next edge; after release, output shall follow REQ-010 from sw_q.

Structure
REQ-024 Package seg7_pkg shall hold the segment constants (digits 0-9, b, A, d, n, BLANK), the mode enum {SHOW,BAD,SCROLL}, and the message array M.
REQ-025 Sub-module seg7_digit shall be combinational: OP_W-bit value in, 7-bit segments out, BLANK for values > 9; one instance per op.
REQ-026 Mode, tick counter, blink phase and p shall live in hex_msg_display; no other sub-modules.

Verification (TICK_DIV=4, defaults otherwise)
REQ-027 SW=00111_00011, wait 2 cycles -> HEX1=1111000, HEX0=0110000, HEX5..2 blank.
REQ-028 SW=10111_00011 -> after 2 cycles HEX5..3=bAd, HEX1 blank, HEX0=0110000; after 4 more cycles HEX5..3 blank; after 4 more, bAd again.
REQ-029 SW=00111_01100 -> HEX5..0 = bAnAnA; after 4 cycles HEX5..0 = A,n,A,n,A,blank; after 32 cycles from entry, back to bAnAnA.
REQ-030 Mid-scroll, change SW to 00111_00011 -> SHOW digits within 2 cycles; return to 00111_01100 -> scroll restarts at p=0.
REQ-031 reset_n=0 during SCROLL -> next edge all HEX=1111111; release with SW=00111_00011 -> digits 2 cycles later.
REQ-032 SW=10111_11011 -> bAd blinking, HEX1 and HEX0 blank; NUM_OPS=3 build: op2=15 -> HEX2 blank and BAD shown.
